// File: rtl/raster_pixel_merge_if.sv
// Pixel merge bus: per-lane input streams plus the single merged output stream.
interface raster_pixel_merge_if #(
    parameter int LANES   = 4,
    parameter int COLOR_W = 4,
    parameter int X_W     = 16,
    parameter int Y_W     = 16,
    parameter int LIDX_W  = $clog2(LANES)
);
    logic [LANES-1:0]         in_vld;
    logic [LANES-1:0]         in_rdy;
    logic [LANES*COLOR_W-1:0] in_color;
    logic [LANES*X_W-1:0]     in_x;
    logic [LANES*Y_W-1:0]     in_y;
    logic [LANES-1:0]         in_last;
    logic                     out_rdy;
    logic                     out_vld;
    logic [COLOR_W-1:0]       out_color;
    logic [X_W-1:0]           out_x;
    logic [Y_W-1:0]           out_y;
    logic                     out_last;
    logic [LIDX_W-1:0]        out_lane;

    // Producer side: pixel lanes and the framebuffer port's ready.
    modport master (
        output in_vld, in_color, in_x, in_y, in_last, out_rdy,
        input  in_rdy, out_vld, out_color, out_x, out_y, out_last, out_lane
    );

    // Merger side.
    modport slave (
        input  in_vld, in_color, in_x, in_y, in_last, out_rdy,
        output in_rdy, out_vld, out_color, out_x, out_y, out_last, out_lane
    );
endinterface

// File: rtl/raster_pixel_merge.sv
// N-lane pixel stream merger: per-lane FIFOs, round-robin or fixed-priority
// arbitration, optional triangle lock, single registered valid/ready output.
module raster_pixel_merge #(
    parameter int LANES    = 4,
    parameter int DEPTH    = 4,
    parameter int COLOR_W  = 4,
    parameter int X_W      = 16,
    parameter int Y_W      = 16,
    parameter int ARB_MODE = 0,
    parameter int LOCK_TRI = 1,
    parameter int LIDX_W   = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    raster_pixel_merge_if.slave  bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = COLOR_W + X_W + Y_W + 1;
    localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [LIDX_W:0] LANES_EXT = (LIDX_W+1)'(LANES);

    // FIFO entry layout: {color, x, y, last}, last in bit 0.
    logic [ENTRY_W-1:0] r_mem  [LANES][DEPTH];
    logic [PTR_W-1:0]   r_wptr [LANES];
    logic [PTR_W-1:0]   r_rptr [LANES];
    logic [PTR_W:0]     r_cnt  [LANES];

    logic [LANES-1:0]   w_full;
    logic [LANES-1:0]   w_empty;
    logic [LANES-1:0]   w_push;
    logic [LANES-1:0]   w_pop;
    logic [LANES-1:0]   w_elig;
    logic [ENTRY_W-1:0] w_wdata [LANES];
    logic [ENTRY_W-1:0] w_rdata;

    logic               w_any;
    logic               w_load;
    logic               w_found;
    logic [LIDX_W-1:0]  w_grant;
    logic [LIDX_W-1:0]  w_cand;
    logic [LIDX_W:0]    w_sum;

    logic               r_out_vld;
    logic [COLOR_W-1:0] r_out_color;
    logic [X_W-1:0]     r_out_x;
    logic [Y_W-1:0]     r_out_y;
    logic               r_out_last;
    logic [LIDX_W-1:0]  r_out_lane;

    logic [LIDX_W-1:0]  r_rr_ptr;
    logic               r_lock_vld;
    logic [LIDX_W-1:0]  r_lock_lane;

    // Per-lane status, push qualification and eligibility (lock narrows to one lane).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_full[i]  = (r_cnt[i] == CNT_FULL);
            w_empty[i] = (r_cnt[i] == '0);
            w_push[i]  = bus.in_vld[i] && !w_full[i];
            w_wdata[i] = {bus.in_color[i*COLOR_W +: COLOR_W],
                          bus.in_x[i*X_W +: X_W],
                          bus.in_y[i*Y_W +: Y_W],
                          bus.in_last[i]};
            w_elig[i]  = !w_empty[i] &&
                         (!r_lock_vld || (r_lock_lane == LIDX_W'(i)));
        end
    end

    assign bus.in_rdy = ~w_full;

    // Arbiter: first eligible lane scanning from the RR pointer, or from lane 0.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        w_sum   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (ARB_MODE == 1) begin
                w_cand = LIDX_W'(k);
            end else begin
                w_sum = {1'b0, r_rr_ptr} + (LIDX_W+1)'(k);
                if (w_sum >= LANES_EXT) begin
                    w_sum = w_sum - LANES_EXT;
                end
                w_cand = w_sum[LIDX_W-1:0];
            end
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_any   = |w_elig;
    assign w_load  = (!r_out_vld || bus.out_rdy) && w_any;
    assign w_rdata = r_mem[w_grant][r_rptr[w_grant]];

    // Pop strobe: only the granted lane, only when the output register loads.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_pop[i] = w_load && (w_grant == LIDX_W'(i));
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= w_wdata[i];
            end
        end
    end

    // FIFO pointers and occupancy; a full lane never accepts, even while popping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_pop[i] && !w_push[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Output register: load on grant, drop valid when drained, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_color <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_last  <= 1'b0;
            r_out_lane  <= '0;
        end else if (w_load) begin
            r_out_vld   <= 1'b1;
            r_out_color <= w_rdata[ENTRY_W-1 -: COLOR_W];
            r_out_x     <= w_rdata[X_W+Y_W -: X_W];
            r_out_y     <= w_rdata[Y_W -: Y_W];
            r_out_last  <= w_rdata[0];
            r_out_lane  <= w_grant;
        end else if (bus.out_rdy) begin
            r_out_vld   <= 1'b0;
        end
    end

    // Round-robin pointer; frozen while a triangle lock is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if ((ARB_MODE == 0) && w_load && !r_lock_vld) begin
            r_rr_ptr <= (w_grant == LIDX_W'(LANES-1)) ? '0 : w_grant + 1'b1;
        end
    end

    // Triangle lock: a non-last beat pins the lane, its last beat releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld  <= 1'b0;
            r_lock_lane <= '0;
        end else if ((LOCK_TRI != 0) && w_load) begin
            r_lock_vld  <= !w_rdata[0];
            r_lock_lane <= w_grant;
        end
    end

    assign bus.out_vld   = r_out_vld;
    assign bus.out_color = r_out_color;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_last  = r_out_last;
    assign bus.out_lane  = r_out_lane;

endmodule

// File: tb/tb_raster_pixel_merge.sv
// Directed bench for raster_pixel_merge: three instances (round-robin,
// fixed priority, round-robin with triangle lock) share one stimulus.
module tb_raster_pixel_merge;

    localparam int LANES   = 4;
    localparam int COLOR_W = 4;
    localparam int X_W     = 16;
    localparam int Y_W     = 16;

    logic clk;
    logic rst_n;

    logic [LANES-1:0]         d_vld;
    logic [LANES*COLOR_W-1:0] d_color;
    logic [LANES*X_W-1:0]     d_x;
    logic [LANES*Y_W-1:0]     d_y;
    logic [LANES-1:0]         d_last;
    logic                     d_rdy;

    int n_run;
    int n_fail;

    int exp_fp_lane [6] = '{0, 0, 0, 2, 2, 2};
    int exp_fp_col  [6] = '{0, 1, 2, 8, 9, 10};
    int exp_rr_lane [6] = '{0, 2, 0, 2, 0, 2};
    int exp_rr_col  [6] = '{0, 8, 1, 9, 2, 10};

    raster_pixel_merge_if #(.LANES(LANES), .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W)) if_rr ();
    raster_pixel_merge_if #(.LANES(LANES), .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W)) if_fp ();
    raster_pixel_merge_if #(.LANES(LANES), .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W)) if_lk ();

    assign if_rr.in_vld   = d_vld;
    assign if_rr.in_color = d_color;
    assign if_rr.in_x     = d_x;
    assign if_rr.in_y     = d_y;
    assign if_rr.in_last  = d_last;
    assign if_rr.out_rdy  = d_rdy;

    assign if_fp.in_vld   = d_vld;
    assign if_fp.in_color = d_color;
    assign if_fp.in_x     = d_x;
    assign if_fp.in_y     = d_y;
    assign if_fp.in_last  = d_last;
    assign if_fp.out_rdy  = d_rdy;

    assign if_lk.in_vld   = d_vld;
    assign if_lk.in_color = d_color;
    assign if_lk.in_x     = d_x;
    assign if_lk.in_y     = d_y;
    assign if_lk.in_last  = d_last;
    assign if_lk.out_rdy  = d_rdy;

    raster_pixel_merge #(.LANES(LANES), .DEPTH(4), .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W),
                         .ARB_MODE(0), .LOCK_TRI(0))
        dut_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));

    raster_pixel_merge #(.LANES(LANES), .DEPTH(4), .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W),
                         .ARB_MODE(1), .LOCK_TRI(0))
        dut_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));

    raster_pixel_merge #(.LANES(LANES), .DEPTH(4), .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W),
                         .ARB_MODE(0), .LOCK_TRI(1))
        dut_lk (.clk(clk), .rst_n(rst_n), .bus(if_lk));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_vld = '0;
    endtask

    task automatic set_lane(input int l, input logic [3:0] c, input logic [15:0] x,
                            input logic [15:0] y, input logic last);
        d_vld[l]                      = 1'b1;
        d_color[l*COLOR_W +: COLOR_W] = c;
        d_x[l*X_W +: X_W]             = x;
        d_y[l*Y_W +: Y_W]             = y;
        d_last[l]                     = last;
    endtask

    task automatic do_reset();
        idle();
        d_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        d_vld   = '0;
        d_color = '0;
        d_x     = '0;
        d_y     = '0;
        d_last  = '0;
        d_rdy   = 1'b0;
        rst_n   = 1'b0;
        #2;

        // reset state
        chk("rst_vld", 32'(if_rr.out_vld), 32'd0);
        chk("rst_rdy", 32'(if_rr.in_rdy), 32'hf);
        do_reset();

        // mid-stream reset with beats buffered
        set_lane(1, 4'd3, 16'h0011, 16'h0021, 1'b0);
        set_lane(2, 4'd4, 16'h0012, 16'h0022, 1'b0);
        set_lane(3, 4'd5, 16'h0013, 16'h0023, 1'b0);
        tick();
        idle();
        tick();
        chk("pre_rst_vld", 32'(if_rr.out_vld), 32'd1);
        chk("pre_rst_lane", 32'(if_rr.out_lane), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(if_rr.out_vld), 32'd0);
        chk("mid_rst_lane", 32'(if_rr.out_lane), 32'd0);
        chk("mid_rst_color", 32'(if_rr.out_color), 32'd0);
        chk("mid_rst_x", 32'(if_rr.out_x), 32'd0);
        chk("mid_rst_y", 32'(if_rr.out_y), 32'd0);
        chk("mid_rst_rdy", 32'(if_rr.in_rdy), 32'hf);
        tick();
        #3;
        rst_n = 1'b1;
        d_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_vld", 32'(if_rr.out_vld), 32'd0);
        end

        // latency: push at edge t, visible after edge t+1
        do_reset();
        d_rdy = 1'b1;
        set_lane(0, 4'd5, 16'd10, 16'd20, 1'b1);
        tick();
        idle();
        chk("lat_early_vld", 32'(if_rr.out_vld), 32'd0);
        tick();
        chk("lat_vld", 32'(if_rr.out_vld), 32'd1);
        chk("lat_color", 32'(if_rr.out_color), 32'd5);
        chk("lat_x", 32'(if_rr.out_x), 32'd10);
        chk("lat_y", 32'(if_rr.out_y), 32'd20);
        chk("lat_last", 32'(if_rr.out_last), 32'd1);
        chk("lat_lane", 32'(if_rr.out_lane), 32'd0);
        tick();
        chk("lat_drop_vld", 32'(if_rr.out_vld), 32'd0);

        // throughput: 8 back-to-back beats on lane 0
        for (int k = 0; k < 10; k++) begin
            if (k < 8) set_lane(0, 4'(k), 16'(100 + k), 16'd0, 1'b1);
            else idle();
            tick();
            if (k >= 1 && k <= 8) begin
                chk("thr_vld", 32'(if_rr.out_vld), 32'd1);
                chk("thr_x", 32'(if_rr.out_x), 32'(100 + k - 1));
            end
        end
        chk("thr_end_vld", 32'(if_rr.out_vld), 32'd0);

        // round-robin: 2 beats per lane, colour encodes output order
        do_reset();
        for (int l = 0; l < LANES; l++) set_lane(l, 4'(l), 16'(l), 16'd0, 1'b0);
        tick();
        for (int l = 0; l < LANES; l++) set_lane(l, 4'(4 + l), 16'(4 + l), 16'd0, 1'b0);
        tick();
        idle();
        d_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_vld", 32'(if_rr.out_vld), 32'd1);
            chk("rr_lane", 32'(if_rr.out_lane), 32'(k % 4));
            chk("rr_color", 32'(if_rr.out_color), 32'(k));
            tick();
        end
        chk("rr_end_vld", 32'(if_rr.out_vld), 32'd0);

        // fixed priority vs round-robin: lanes 0 and 2 with 3 beats each
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_lane(0, 4'(b), 16'(b), 16'd0, 1'b0);
            set_lane(2, 4'(8 + b), 16'(8 + b), 16'd0, 1'b0);
            tick();
        end
        idle();
        d_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("fp_vld", 32'(if_fp.out_vld), 32'd1);
            chk("fp_lane", 32'(if_fp.out_lane), 32'(exp_fp_lane[k]));
            chk("fp_color", 32'(if_fp.out_color), 32'(exp_fp_col[k]));
            chk("rr2_lane", 32'(if_rr.out_lane), 32'(exp_rr_lane[k]));
            chk("rr2_color", 32'(if_rr.out_color), 32'(exp_rr_col[k]));
            tick();
        end
        chk("fp_end_vld", 32'(if_fp.out_vld), 32'd0);

        // triangle lock: lane 1 stalls mid-triangle, lane 0 must wait
        do_reset();
        d_rdy = 1'b1;
        set_lane(1, 4'd1, 16'd1, 16'd0, 1'b0);
        tick();
        idle();
        tick();
        chk("lk_b0_vld", 32'(if_lk.out_vld), 32'd1);
        chk("lk_b0_lane", 32'(if_lk.out_lane), 32'd1);
        chk("lk_b0_last", 32'(if_lk.out_last), 32'd0);
        set_lane(0, 4'd8, 16'd8, 16'd0, 1'b1);
        tick();
        chk("lk_stall1_vld", 32'(if_lk.out_vld), 32'd0);
        set_lane(0, 4'd9, 16'd9, 16'd0, 1'b1);
        tick();
        chk("lk_stall2_vld", 32'(if_lk.out_vld), 32'd0);
        chk("nolk_vld", 32'(if_rr.out_vld), 32'd1);
        chk("nolk_color", 32'(if_rr.out_color), 32'd8);
        idle();
        tick();
        chk("lk_stall3_vld", 32'(if_lk.out_vld), 32'd0);
        set_lane(1, 4'd2, 16'd2, 16'd0, 1'b0);
        tick();
        chk("lk_stall4_vld", 32'(if_lk.out_vld), 32'd0);
        set_lane(1, 4'd3, 16'd3, 16'd0, 1'b1);
        tick();
        idle();
        chk("lk_b1_lane", 32'(if_lk.out_lane), 32'd1);
        chk("lk_b1_color", 32'(if_lk.out_color), 32'd2);
        tick();
        chk("lk_b2_lane", 32'(if_lk.out_lane), 32'd1);
        chk("lk_b2_color", 32'(if_lk.out_color), 32'd3);
        chk("lk_b2_last", 32'(if_lk.out_last), 32'd1);
        tick();
        chk("lk_l0a_lane", 32'(if_lk.out_lane), 32'd0);
        chk("lk_l0a_color", 32'(if_lk.out_color), 32'd8);
        tick();
        chk("lk_l0b_lane", 32'(if_lk.out_lane), 32'd0);
        chk("lk_l0b_color", 32'(if_lk.out_color), 32'd9);
        tick();
        chk("lk_end_vld", 32'(if_lk.out_vld), 32'd0);

        // backpressure and full lane 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_lane(3, 4'(k), 16'(16'h300 + k), 16'(k), 1'b1);
            tick();
            chk("bp_rdy3", 32'(if_rr.in_rdy[3]), (k < 4) ? 32'd1 : 32'd0);
            if (k >= 1) chk("bp_hold_x", 32'(if_rr.out_x), 32'h300);
        end
        set_lane(3, 4'hf, 16'd99, 16'd99, 1'b1);
        tick();
        chk("bp_full_rdy3", 32'(if_rr.in_rdy[3]), 32'd0);
        chk("bp_full_vld", 32'(if_rr.out_vld), 32'd1);
        chk("bp_full_x", 32'(if_rr.out_x), 32'h300);
        d_rdy = 1'b1;
        tick();
        idle();
        chk("bp_rel_x", 32'(if_rr.out_x), 32'h301);
        for (int j = 2; j < 5; j++) begin
            tick();
            chk("bp_drain_vld", 32'(if_rr.out_vld), 32'd1);
            chk("bp_drain_x", 32'(if_rr.out_x), 32'(32'h300 + j));
        end
        tick();
        chk("bp_end_vld", 32'(if_rr.out_vld), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/raster_pixel_merge.md
Name: raster_pixel_merge

Overview:
Parametrised N-lane pixel stream merger. It sits between a bank of parallel pixel-processor lanes and the single framebuffer write port, and is the multi-lane successor to the single tile→pixel raster chain. Each lane has its own FIFO. A configurable arbiter (round-robin or fixed priority) feeds one registered valid/ready output stream. An optional triangle-lock mode keeps each triangle's pixels contiguous on the output.

Parameters:
LANES, 4, number of input pixel lanes (≥2)
DEPTH, 4, entries per lane FIFO (power of 2, ≥2)
COLOR_W, 4, color field width
X_W, 16, pixel x width
Y_W, 16, pixel y width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lane 0 highest)
LOCK_TRI, 1, 1 = hold grant on a lane until its last=1 beat is popped
LIDX_W, $clog2(LANES), lane index width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_vld  in  LANES  per-lane valid
in_rdy  out  LANES  per-lane ready (FIFO not full)
in_color  in  LANES*COLOR_W  packed color, lane i at [i*COLOR_W +: COLOR_W]
in_x  in  LANES*X_W  packed pixel x
in_y  in  LANES*Y_W  packed pixel y
in_last  in  LANES  final pixel of the current triangle on that lane
out_rdy  in  1  downstream ready
out_vld  out  1  output valid (registered)
out_color  out  COLOR_W  merged color
out_x  out  X_W  merged x
out_y  out  Y_W  merged y
out_last  out  1  forwarded last flag
out_lane  out  LIDX_W  source lane of the current beat

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). In reset: all FIFOs empty; out_vld, out_color, out_x, out_y, out_last, out_lane = 0; RR pointer = 0; lock cleared; in_rdy = all 1s.
- Reset asserted mid-operation discards all FIFO contents and the output register immediately. No partial beat is emitted after release.
- Push: lane i writes {color, x, y, last} when in_vld[i] && in_rdy[i]. in_rdy[i] = !full[i], combinational from the occupancy count.
- A full FIFO refuses a push even when it pops in the same cycle (no pass-through). Push and pop on a non-full, non-empty lane in the same cycle leave the count unchanged.
- Output register loads when (!out_vld || out_rdy) and at least one lane is eligible. Loading pops the granted lane in the same cycle.
- If nothing is eligible and out_rdy=1, out_vld drops to 0 on the next edge.
- While out_vld && !out_rdy, all out_* hold stable. No pop occurs.
- Latency: a beat accepted at edge t into an empty system appears with out_vld=1 in the cycle after edge t+1 (2 cycles).
- Full throughput: with out_rdy held at 1 and any lane non-empty, one beat is output per cycle.
- Eligible set = non-empty lanes, except when locked: then only the locked lane is eligible.
- ARB_MODE=0: search starts at RR pointer and wraps modulo LANES. After a grant, pointer = granted+1 (wraps LANES-1 → 0).
- ARB_MODE=1: lowest-index eligible lane wins. RR pointer is unused.
- LOCK_TRI=1: popping a beat with last=0 sets lock on that lane. Popping a beat with last=1 clears it.
- If the locked lane is empty, the output bubbles (out_vld falls once drained); other lanes wait.
- The RR pointer does not advance during a lock.
- LOCK_TRI=0: lock is never set and last is only forwarded.
- FIFO pointers are LOG2(DEPTH)-bit and wrap naturally. Count is LOG2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- out_lane equals the index of the lane popped for the current output beat.

Test Plan:
- Reset: LANES=4. Drive rst_n=0 mid-stream with 3 beats buffered → out_vld=0, out_* =0, in_rdy=4'b1111. After release, no stale beat appears.
- Latency/throughput: lane 0 pushes (c=5, x=10, y=20, last=1) at edge t → out_vld=1 with those values after edge t+1. 8 back-to-back beats with out_rdy=1 → 8 consecutive out_vld cycles.
- Round-robin (ARB_MODE=0, LOCK_TRI=0): all 4 lanes hold 2 beats each, out_rdy=1 → out_lane sequence 0,1,2,3,0,1,2,3.
- Fixed priority (ARB_MODE=1): lanes 0 and 2 hold 3 beats each → out_lane 0,0,0,2,2,2.
- Triangle lock (LOCK_TRI=1): lane 1 queues last=0,0,1 and lane 0 queues 2 beats. Lane 1 is granted first → three lane-1 beats contiguous, then lane 0. With lane 1 stalled empty after its first beat, out_vld drops and lane 0 is not served.
- Backpressure/full: out_rdy=0, lane 3 pushes 5 beats → in_rdy[3]=0 after 4 (DEPTH) plus the 1 in the output register. Outputs hold stable. Release out_rdy → all 5 beats emitted in order, none lost or duplicated.
